// File: rtl/tube_access_arbiter.sv
// Two-requester arbiter and cycle sequencer for the Tube parasite register bus.
// Define TUBE_ARB_RR_EN for round-robin tie-breaking; otherwise the host wins ties.
module tube_access_arbiter #(
  parameter int SETUP_CYCLES     = 1,
  parameter int PHI2_HIGH_CYCLES = 2,
  parameter int HOLD_CYCLES      = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       H_REQ,
  input  logic       H_RNW,
  input  logic [2:0] H_ADR,
  input  logic [7:0] H_WDATA,
  output logic       H_ACK,
  output logic [7:0] H_RDATA,
  input  logic       P_REQ,
  input  logic       P_RNW,
  input  logic [2:0] P_ADR,
  input  logic [7:0] P_WDATA,
  output logic       P_ACK,
  output logic [7:0] P_RDATA,
  output logic       BUSY,
  output logic       TUBE_CS_B,
  output logic       TUBE_RNW_B,
  output logic       TUBE_PHI2,
  output logic [2:0] TUBE_ADR,
  output logic [7:0] TUBE_DOUT,
  output logic       TUBE_DOE,
  input  logic [7:0] TUBE_DIN
);

  localparam int SETUP_EFF = (SETUP_CYCLES < 1) ? 1 : ((SETUP_CYCLES > 15) ? 15 : SETUP_CYCLES);
  localparam int HIGH_EFF  = (PHI2_HIGH_CYCLES < 1) ? 1 : ((PHI2_HIGH_CYCLES > 15) ? 15 : PHI2_HIGH_CYCLES);
  localparam int HOLD_EFF  = (HOLD_CYCLES < 1) ? 1 : ((HOLD_CYCLES > 15) ? 15 : HOLD_CYCLES);
  localparam logic [3:0] SETUP_LD = 4'(SETUP_EFF - 1);
  localparam logic [3:0] HIGH_LD  = 4'(HIGH_EFF - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_EFF - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_HIGH, ST_HOLD} state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       owner_reg;              // 1 = poller owns the current access
  logic       rnw_reg;
  logic [2:0] adr_reg;
  logic [7:0] wdata_reg;
  logic       cs_b_reg, cs_b_next;
  logic       rnw_b_reg, rnw_b_next;
  logic       phi2_reg, phi2_next;
  logic       doe_reg, doe_next;
  logic       h_ack_reg, h_ack_next;
  logic       p_ack_reg, p_ack_next;
  logic       busy_reg;
  logic [7:0] h_rdata_reg, p_rdata_reg;
  logic       grant, grant_p, capture, eff_rnw, last_hold;

  assign grant = (state_reg == ST_IDLE) && (H_REQ || P_REQ);

`ifdef TUBE_ARB_RR_EN
  logic prio_p_reg;                   // 1 = poller wins the next tie
  assign grant_p = P_REQ && (!H_REQ || prio_p_reg);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      prio_p_reg <= 1'b0;
    end else if (grant) begin
      prio_p_reg <= ~grant_p;
    end
  end
`else
  assign grant_p = P_REQ && !H_REQ;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (grant) begin
          state_next = ST_SETUP;
          cnt_next   = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_HIGH;
          cnt_next   = HIGH_LD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_HIGH: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_HOLD;
          cnt_next   = HOLD_LD;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Outputs are computed from the upcoming state so the flops present them
    // in the same cycle the FSM occupies that state.
    eff_rnw    = (state_reg == ST_IDLE) ? (grant_p ? P_RNW : H_RNW) : rnw_reg;
    cs_b_next  = (state_next == ST_IDLE);
    rnw_b_next = cs_b_next ? 1'b1 : eff_rnw;
    phi2_next  = (state_next == ST_HIGH);
    doe_next   = ((state_next == ST_HIGH) || (state_next == ST_HOLD)) && !eff_rnw;
    last_hold  = (state_next == ST_HOLD) && (cnt_next == 4'd0);
    h_ack_next = last_hold && !owner_reg;
    p_ack_next = last_hold && owner_reg;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= 4'd0;
      owner_reg   <= 1'b0;
      rnw_reg     <= 1'b1;
      adr_reg     <= 3'd0;
      wdata_reg   <= 8'd0;
      cs_b_reg    <= 1'b1;
      rnw_b_reg   <= 1'b1;
      phi2_reg    <= 1'b0;
      doe_reg     <= 1'b0;
      h_ack_reg   <= 1'b0;
      p_ack_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      h_rdata_reg <= 8'd0;
      p_rdata_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      cs_b_reg  <= cs_b_next;
      rnw_b_reg <= rnw_b_next;
      phi2_reg  <= phi2_next;
      doe_reg   <= doe_next;
      h_ack_reg <= h_ack_next;
      p_ack_reg <= p_ack_next;
      busy_reg  <= !cs_b_next;
      if (grant) begin
        owner_reg <= grant_p;
        rnw_reg   <= grant_p ? P_RNW : H_RNW;
        adr_reg   <= grant_p ? P_ADR : H_ADR;
        wdata_reg <= grant_p ? P_WDATA : H_WDATA;
      end
      if (capture && rnw_reg) begin
        if (owner_reg) begin
          p_rdata_reg <= TUBE_DIN;
        end else begin
          h_rdata_reg <= TUBE_DIN;
        end
      end
    end
  end

  assign H_ACK      = h_ack_reg;
  assign P_ACK      = p_ack_reg;
  assign H_RDATA    = h_rdata_reg;
  assign P_RDATA    = p_rdata_reg;
  assign BUSY       = busy_reg;
  assign TUBE_CS_B  = cs_b_reg;
  assign TUBE_RNW_B = rnw_b_reg;
  assign TUBE_PHI2  = phi2_reg;
  assign TUBE_ADR   = adr_reg;
  assign TUBE_DOUT  = wdata_reg;
  assign TUBE_DOE   = doe_reg;

endmodule

// File: tb/tb_tube_access_arbiter.sv
// Self-checking bench for tube_access_arbiter: default-timed and 2/3/2-timed instances
// checked cycle by cycle against a phase-arithmetic model of each access.
module tb_tube_access_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       h_req, h_rnw, p_req, p_rnw;
  logic [2:0] h_adr, p_adr;
  logic [7:0] h_wdata, p_wdata, tube_din;
  logic       use2;

  logic       o1_hack, o1_pack, o1_busy, o1_cs_b, o1_rnw_b, o1_phi2, o1_doe;
  logic [7:0] o1_hrd, o1_prd, o1_dout;
  logic [2:0] o1_adr;
  logic       o2_hack, o2_pack, o2_busy, o2_cs_b, o2_rnw_b, o2_phi2, o2_doe;
  logic [7:0] o2_hrd, o2_prd, o2_dout;
  logic [2:0] o2_adr;

  logic       q_hack, q_pack, q_busy, q_cs_b, q_rnw_b, q_phi2, q_doe;
  logic [7:0] q_hrd, q_prd, q_dout;
  logic [2:0] q_adr;

  int         vectors = 0;
  int         errs = 0;
  logic [7:0] ref_hrd, ref_prd;
  logic       ref_prio_p;

  always #5 clk = ~clk;

  tube_access_arbiter dut (
    .CLK(clk), .RESET(rst),
    .H_REQ(h_req), .H_RNW(h_rnw), .H_ADR(h_adr), .H_WDATA(h_wdata),
    .H_ACK(o1_hack), .H_RDATA(o1_hrd),
    .P_REQ(p_req), .P_RNW(p_rnw), .P_ADR(p_adr), .P_WDATA(p_wdata),
    .P_ACK(o1_pack), .P_RDATA(o1_prd),
    .BUSY(o1_busy), .TUBE_CS_B(o1_cs_b), .TUBE_RNW_B(o1_rnw_b), .TUBE_PHI2(o1_phi2),
    .TUBE_ADR(o1_adr), .TUBE_DOUT(o1_dout), .TUBE_DOE(o1_doe), .TUBE_DIN(tube_din)
  );

  tube_access_arbiter #(.SETUP_CYCLES(2), .PHI2_HIGH_CYCLES(3), .HOLD_CYCLES(2)) dut2 (
    .CLK(clk), .RESET(rst),
    .H_REQ(h_req), .H_RNW(h_rnw), .H_ADR(h_adr), .H_WDATA(h_wdata),
    .H_ACK(o2_hack), .H_RDATA(o2_hrd),
    .P_REQ(p_req), .P_RNW(p_rnw), .P_ADR(p_adr), .P_WDATA(p_wdata),
    .P_ACK(o2_pack), .P_RDATA(o2_prd),
    .BUSY(o2_busy), .TUBE_CS_B(o2_cs_b), .TUBE_RNW_B(o2_rnw_b), .TUBE_PHI2(o2_phi2),
    .TUBE_ADR(o2_adr), .TUBE_DOUT(o2_dout), .TUBE_DOE(o2_doe), .TUBE_DIN(tube_din)
  );

  assign q_hack  = use2 ? o2_hack  : o1_hack;
  assign q_pack  = use2 ? o2_pack  : o1_pack;
  assign q_busy  = use2 ? o2_busy  : o1_busy;
  assign q_cs_b  = use2 ? o2_cs_b  : o1_cs_b;
  assign q_rnw_b = use2 ? o2_rnw_b : o1_rnw_b;
  assign q_phi2  = use2 ? o2_phi2  : o1_phi2;
  assign q_doe   = use2 ? o2_doe   : o1_doe;
  assign q_hrd   = use2 ? o2_hrd   : o1_hrd;
  assign q_prd   = use2 ? o2_prd   : o1_prd;
  assign q_dout  = use2 ? o2_dout  : o1_dout;
  assign q_adr   = use2 ? o2_adr   : o1_adr;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".cs_b"},  {7'd0, q_cs_b},  8'd1);
    chk({tag, ".rnw_b"}, {7'd0, q_rnw_b}, 8'd1);
    chk({tag, ".phi2"},  {7'd0, q_phi2},  8'd0);
    chk({tag, ".doe"},   {7'd0, q_doe},   8'd0);
    chk({tag, ".busy"},  {7'd0, q_busy},  8'd0);
    chk({tag, ".hack"},  {7'd0, q_hack},  8'd0);
    chk({tag, ".pack"},  {7'd0, q_pack},  8'd0);
    chk({tag, ".hrd"},   q_hrd, ref_hrd);
    chk({tag, ".prd"},   q_prd, ref_prd);
  endtask

  // Applies reset for one edge and checks every output the cycle after.
  task automatic do_reset();
    rst = 1'b1;
    h_req = 1'b0;
    p_req = 1'b0;
    @(posedge clk); #1;
    ref_hrd = 8'd0;
    ref_prd = 8'd0;
    ref_prio_p = 1'b0;
    check_idle("rst");
    chk("rst.adr",  {5'd0, q_adr}, 8'd0);
    chk("rst.dout", q_dout, 8'd0);
    rst = 1'b0;
  endtask

  // Called in an IDLE cycle with requests already driven; follows one whole access
  // plus the IDLE cycle after it. w_obs reports which ACK actually pulsed.
  task automatic run_access(input int s, input int hc, input int d, input bit hold_all,
                            input int drop_k, output logic w_obs);
    logic       w, rnw, in_high, after_high;
    logic [2:0] adr;
    logic [7:0] wd, dv;
    int         total;
    if (h_req && p_req) begin
`ifdef TUBE_ARB_RR_EN
      w = ref_prio_p;
`else
      w = 1'b0;
`endif
    end else begin
      w = p_req;
    end
    ref_prio_p = ~w;
    rnw   = w ? p_rnw : h_rnw;
    adr   = w ? p_adr : h_adr;
    wd    = w ? p_wdata : h_wdata;
    dv    = 8'($urandom);
    total = s + hc + d;
    w_obs = 1'bx;
    for (int k = 1; k <= total; k++) begin
      @(posedge clk); #1;
      in_high    = (k > s) && (k <= s + hc);
      after_high = (k > s);
      chk("cs_b",  {7'd0, q_cs_b},  8'd0);
      chk("phi2",  {7'd0, q_phi2},  {7'd0, in_high});
      chk("rnw_b", {7'd0, q_rnw_b}, {7'd0, rnw});
      chk("adr",   {5'd0, q_adr},   {5'd0, adr});
      chk("doe",   {7'd0, q_doe},   {7'd0, !rnw && after_high});
      if (!rnw && after_high) chk("dout", q_dout, wd);
      chk("busy",  {7'd0, q_busy},  8'd1);
      chk("hack",  {7'd0, q_hack},  {7'd0, (k == total) && !w});
      chk("pack",  {7'd0, q_pack},  {7'd0, (k == total) && w});
      chk("hrd", q_hrd, (!w && rnw && k > s + hc) ? dv : ref_hrd);
      chk("prd", q_prd, ( w && rnw && k > s + hc) ? dv : ref_prd);
      if (q_hack) w_obs = 1'b0;
      if (q_pack) w_obs = 1'b1;
      tube_din = (k == s + hc) ? dv : 8'($urandom);
      if (k == drop_k || (k == total && !hold_all)) begin
        if (w) p_req = 1'b0;
        else   h_req = 1'b0;
      end
    end
    if (rnw) begin
      if (w) ref_prd = dv;
      else   ref_hrd = dv;
    end
    @(posedge clk); #1;
    check_idle("gap");
  endtask

  initial begin
    logic wo;
    logic [3:0] tie_exp;
    int drop;
    use2 = 1'b0;
    rst = 1'b1;
    h_req = 1'b0; h_rnw = 1'b1; h_adr = 3'd0; h_wdata = 8'd0;
    p_req = 1'b0; p_rnw = 1'b1; p_adr = 3'd0; p_wdata = 8'd0;
    tube_din = 8'd0;
    repeat (3) @(posedge clk);
    do_reset();

    // Host read of register 3
    h_req = 1'b1; h_rnw = 1'b1; h_adr = 3'd3;
    run_access(1, 2, 1, 1'b0, 0, wo);
    chk("host_read.owner", {7'd0, wo}, 8'd0);

    // Poller write of 0xC3 to register 1
    p_req = 1'b1; p_rnw = 1'b0; p_adr = 3'd1; p_wdata = 8'hC3;
    run_access(1, 2, 1, 1'b0, 0, wo);
    chk("poll_write.owner", {7'd0, wo}, 8'd1);

    // Random mix of single, overlapping and mid-access-dropped requests
    for (int i = 0; i < 24; i++) begin
      if (!h_req && $urandom_range(0, 1) == 1) begin
        h_req = 1'b1; h_rnw = 1'($urandom); h_adr = 3'($urandom); h_wdata = 8'($urandom);
      end
      if (!p_req && $urandom_range(0, 1) == 1) begin
        p_req = 1'b1; p_rnw = 1'($urandom); p_adr = 3'($urandom); p_wdata = 8'($urandom);
      end
      if (!h_req && !p_req) begin
        h_req = 1'b1; h_rnw = 1'($urandom); h_adr = 3'($urandom); h_wdata = 8'($urandom);
      end
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_access(1, 2, 1, 1'b0, drop, wo);
    end
    h_req = 1'b0;
    p_req = 1'b0;
    @(posedge clk); #1;

    // Both requesters held for four accesses
    do_reset();
`ifdef TUBE_ARB_RR_EN
    tie_exp = 4'b1010;
`else
    tie_exp = 4'b0000;
`endif
    h_req = 1'b1; h_rnw = 1'b1; h_adr = 3'd2;
    p_req = 1'b1; p_rnw = 1'b0; p_adr = 3'd6; p_wdata = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      run_access(1, 2, 1, 1'b1, 0, wo);
      chk($sformatf("tie%0d.owner", i), {7'd0, wo}, {7'd0, tie_exp[i]});
    end
    h_req = 1'b0;
    p_req = 1'b0;
    @(posedge clk); #1;
    check_idle("tie_end");

    // Reset in the second HIGH cycle aborts without ACK or RDATA update
    h_req = 1'b1; h_rnw = 1'b1; h_adr = 3'd5;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort.phi2", {7'd0, q_phi2}, 8'd1);
    tube_din = 8'hA5;
    do_reset();
    @(posedge clk); #1;
    check_idle("abort_after");
    h_req = 1'b1; h_rnw = 1'b1; h_adr = 3'd4;
    run_access(1, 2, 1, 1'b0, 0, wo);
    chk("abort_recover.owner", {7'd0, wo}, 8'd0);

    // Stretched 2/3/2 timing: read then write
    do_reset();
    use2 = 1'b1;
    #1;
    h_req = 1'b1; h_rnw = 1'b1; h_adr = 3'd3;
    run_access(2, 3, 2, 1'b0, 0, wo);
    chk("slow_read.owner", {7'd0, wo}, 8'd0);
    p_req = 1'b1; p_rnw = 1'b0; p_adr = 3'd7; p_wdata = 8'h96;
    run_access(2, 3, 2, 1'b0, 0, wo);
    chk("slow_write.owner", {7'd0, wo}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
